// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared definitions for the raster timing generator: the DK board preset
// and the helpers used by each axis counter to place its sync window.
// No ports (package).
package video_timing_pkg;

  // DK board raster: 384x264 total, 256x224 visible.
  localparam int DK_H_TOTAL      = 384;
  localparam int DK_H_ACTIVE     = 256;
  localparam int DK_H_SYNC_START = 288;
  localparam int DK_H_SYNC_LEN   = 32;
  localparam int DK_V_TOTAL      = 264;
  localparam int DK_V_ACTIVE     = 224;
  localparam int DK_V_SYNC_START = 240;
  localparam int DK_V_SYNC_LEN   = 8;

  // Sync start moved by a signed offset, folded back into 0..total-1.
  // Offsets are much smaller than total, so one correction step is enough.
  function automatic int wrap_start(input int start, input int ofs, input int total);
    int s;
    s = start + ofs;
    if (s < 0) begin
      s = s + total;
    end else if (s >= total) begin
      s = s - total;
    end
    return s;
  endfunction

  // True when pos lies in the len-wide window beginning at start. The window
  // may run past total-1 and continue from 0.
  function automatic logic in_window(input int pos, input int start, input int len,
                                     input int total);
    int stop;
    stop = start + len;
    if (stop <= total) begin
      return (pos >= start) && (pos < stop);
    end
    return (pos >= start) || (pos < stop - total);
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter
// One raster axis: position counter with wrap, blank and sync decode, flip
// mux, and frame-latched shadow copies of the offset and flip requests.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   advance      step the count on this edge
//   load         latch ofs_in/flip_in into the shadows on this edge
//   ofs_in       signed sync shift request
//   flip_in      flip request
//   cnt          current position
//   flip_cnt     position mirrored inside the active area when flipped
//   blank_n      low outside the active area
//   sync_n       low inside the (shifted) sync window
//   wrap         count is at its last value
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int W          = 9,
  parameter int TOTAL      = 384,
  parameter int ACTIVE     = 256,
  parameter int SYNC_START = 288,
  parameter int SYNC_LEN   = 32,
  parameter int OFS_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             load,
  input  logic [OFS_W-1:0] ofs_in,
  input  logic             flip_in,
  output logic [W-1:0]     cnt,
  output logic [W-1:0]     flip_cnt,
  output logic             blank_n,
  output logic             sync_n,
  output logic             wrap
);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT      = W'(ACTIVE);
  localparam logic [W-1:0] ACT_LAST = W'(ACTIVE - 1);

  logic [W-1:0]     cnt_next;
  logic [W-1:0]     flip_cnt_next;
  logic [OFS_W-1:0] ofs;
  logic [OFS_W-1:0] ofs_next;
  logic             flip;
  logic             flip_next;
  logic             blank_next;
  logic             sync_next;
  int               sync_start;

  assign wrap = (cnt == LAST);

  // Decode from the next count and next shadow values so the registered
  // blank/sync/flip outputs line up with the count they describe, and a
  // shadow loaded at frame wrap already governs position 0 of the new frame.
  always_comb begin
    cnt_next = cnt;
    if (advance) begin
      cnt_next = wrap ? '0 : cnt + W'(1);
    end
    ofs_next      = load ? ofs_in : ofs;
    flip_next     = load ? flip_in : flip;
    sync_start    = wrap_start(SYNC_START, int'($signed(ofs_next)), TOTAL);
    blank_next    = (cnt_next >= ACT);
    sync_next     = in_window(int'(cnt_next), sync_start, SYNC_LEN, TOTAL);
    flip_cnt_next = cnt_next;
    if (flip_next && !blank_next) begin
      flip_cnt_next = ACT_LAST - cnt_next;
    end
  end

  // State and registered outputs; reset forces inactive blank/sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ofs      <= '0;
      flip     <= 1'b0;
      blank_n  <= 1'b1;
      sync_n   <= 1'b1;
      flip_cnt <= '0;
    end else begin
      cnt      <= cnt_next;
      ofs      <= ofs_next;
      flip     <= flip_next;
      blank_n  <= !blank_next;
      sync_n   <= !sync_next;
      flip_cnt <= flip_cnt_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Raster timing generator: divides the master clock to a pixel enable and
// drives horizontal/vertical counts, blanks, syncs, flipped counts and
// line/frame strobes. Sync offsets and flips take effect on frame wrap.
// Ports:
//   I_CLK, RST_n               master clock, asynchronous active-low reset
//   I_H_FLIP, I_V_FLIP         flip requests
//   I_H_OFS, I_V_OFS           signed sync shifts (pixels / lines)
//   O_CLK_EN                   pixel enable
//   O_H_CNT, O_V_CNT           raster position
//   O_HF_CNT, O_VF_CNT         flip-adjusted position
//   O_H_BLANKn, O_V_BLANKn, O_C_BLANKn   active-low blanks
//   O_H_SYNCn, O_V_SYNCn       active-low syncs
//   O_LINE_STB, O_FRAME_STB    last pixel of line / frame
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int H_W          = 9,
  parameter int V_W          = 9,
  parameter int H_TOTAL      = DK_H_TOTAL,
  parameter int H_ACTIVE     = DK_H_ACTIVE,
  parameter int H_SYNC_START = DK_H_SYNC_START,
  parameter int H_SYNC_LEN   = DK_H_SYNC_LEN,
  parameter int V_TOTAL      = DK_V_TOTAL,
  parameter int V_ACTIVE     = DK_V_ACTIVE,
  parameter int V_SYNC_START = DK_V_SYNC_START,
  parameter int V_SYNC_LEN   = DK_V_SYNC_LEN,
  parameter int OFS_W        = 4
) (
  input  logic             I_CLK,
  input  logic             RST_n,
  input  logic             I_H_FLIP,
  input  logic             I_V_FLIP,
  input  logic [OFS_W-1:0] I_H_OFS,
  input  logic [OFS_W-1:0] I_V_OFS,
  output logic             O_CLK_EN,
  output logic [H_W-1:0]   O_H_CNT,
  output logic [V_W-1:0]   O_V_CNT,
  output logic [H_W-1:0]   O_HF_CNT,
  output logic [V_W-1:0]   O_VF_CNT,
  output logic             O_H_BLANKn,
  output logic             O_V_BLANKn,
  output logic             O_C_BLANKn,
  output logic             O_H_SYNCn,
  output logic             O_V_SYNCn,
  output logic             O_LINE_STB,
  output logic             O_FRAME_STB
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL) begin : g_bad_active
    $error("video_timing_gen: active area must be smaller than total");
  end
  if (H_SYNC_LEN >= H_TOTAL - H_ACTIVE || V_SYNC_LEN >= V_TOTAL - V_ACTIVE) begin : g_bad_sync
    $error("video_timing_gen: sync length must be shorter than blank interval");
  end
  if (H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W)) begin : g_bad_width
    $error("video_timing_gen: count width too small for total");
  end

  localparam int D_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [D_W-1:0] D_LAST = D_W'(CLK_DIV - 1);

  logic [D_W-1:0] div;
  logic           clk_en;
  logic           h_wrap;
  logic           v_wrap;
  logic           line_stb;
  logic           frame_stb;
  logic           h_blank_n;
  logic           v_blank_n;

  // Pixel divider. With CLK_DIV=1 it sits at 0 and the enable stays high.
  always_ff @(posedge I_CLK or negedge RST_n) begin
    if (!RST_n) begin
      div <= '0;
    end else begin
      div <= (div == D_LAST) ? '0 : div + D_W'(1);
    end
  end

  assign clk_en    = (div == D_LAST);
  assign line_stb  = clk_en & h_wrap;
  assign frame_stb = line_stb & v_wrap;

  video_axis_counter #(
    .W          (H_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_LEN   (H_SYNC_LEN),
    .OFS_W      (OFS_W)
  ) u_h (
    .clk      (I_CLK),
    .rst_n    (RST_n),
    .advance  (clk_en),
    .load     (frame_stb),
    .ofs_in   (I_H_OFS),
    .flip_in  (I_H_FLIP),
    .cnt      (O_H_CNT),
    .flip_cnt (O_HF_CNT),
    .blank_n  (h_blank_n),
    .sync_n   (O_H_SYNCn),
    .wrap     (h_wrap)
  );

  // The vertical axis steps once per line, on the last pixel's enable.
  video_axis_counter #(
    .W          (V_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_LEN   (V_SYNC_LEN),
    .OFS_W      (OFS_W)
  ) u_v (
    .clk      (I_CLK),
    .rst_n    (RST_n),
    .advance  (line_stb),
    .load     (frame_stb),
    .ofs_in   (I_V_OFS),
    .flip_in  (I_V_FLIP),
    .cnt      (O_V_CNT),
    .flip_cnt (O_VF_CNT),
    .blank_n  (v_blank_n),
    .sync_n   (O_V_SYNCn),
    .wrap     (v_wrap)
  );

  assign O_CLK_EN    = clk_en;
  assign O_H_BLANKn  = h_blank_n;
  assign O_V_BLANKn  = v_blank_n;
  assign O_C_BLANKn  = h_blank_n & v_blank_n;
  assign O_LINE_STB  = line_stb;
  assign O_FRAME_STB = frame_stb;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// Directed bench. Three instances share clock, reset and control inputs:
//   d_*  DK defaults, CLK_DIV=2 (reset and first-line checks)
//   s_*  small 24x12 raster, CLK_DIV=2 (frame, offset, flip, reset-mid)
//   o_*  small raster, CLK_DIV=1 (continuous enable)
// Small raster: H 24 total / 16 active / sync 18+3, V 12 / 8 / sync 9+2.
module tb_video_timing_gen;

  logic       clk;
  logic       rst_n;
  logic       h_flip;
  logic       v_flip;
  logic [3:0] h_ofs;
  logic [3:0] v_ofs;

  logic       d_clk_en, d_h_blank_n, d_v_blank_n, d_c_blank_n, d_h_sync_n, d_v_sync_n;
  logic       d_line_stb, d_frame_stb;
  logic [8:0] d_h_cnt, d_v_cnt, d_hf_cnt, d_vf_cnt;

  logic       s_clk_en, s_h_blank_n, s_v_blank_n, s_c_blank_n, s_h_sync_n, s_v_sync_n;
  logic       s_line_stb, s_frame_stb;
  logic [8:0] s_h_cnt, s_v_cnt, s_hf_cnt, s_vf_cnt;

  logic       o_clk_en, o_h_blank_n, o_v_blank_n, o_c_blank_n, o_h_sync_n, o_v_sync_n;
  logic       o_line_stb, o_frame_stb;
  logic [8:0] o_h_cnt, o_v_cnt, o_hf_cnt, o_vf_cnt;

  int n_vec = 0;
  int n_err = 0;
  int tmo   = 0;

  video_timing_gen dut_d (
    .I_CLK(clk), .RST_n(rst_n), .I_H_FLIP(h_flip), .I_V_FLIP(v_flip),
    .I_H_OFS(h_ofs), .I_V_OFS(v_ofs), .O_CLK_EN(d_clk_en),
    .O_H_CNT(d_h_cnt), .O_V_CNT(d_v_cnt), .O_HF_CNT(d_hf_cnt), .O_VF_CNT(d_vf_cnt),
    .O_H_BLANKn(d_h_blank_n), .O_V_BLANKn(d_v_blank_n), .O_C_BLANKn(d_c_blank_n),
    .O_H_SYNCn(d_h_sync_n), .O_V_SYNCn(d_v_sync_n),
    .O_LINE_STB(d_line_stb), .O_FRAME_STB(d_frame_stb)
  );

  video_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(24), .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_LEN(3),
    .V_TOTAL(12), .V_ACTIVE(8), .V_SYNC_START(9), .V_SYNC_LEN(2)
  ) dut_s (
    .I_CLK(clk), .RST_n(rst_n), .I_H_FLIP(h_flip), .I_V_FLIP(v_flip),
    .I_H_OFS(h_ofs), .I_V_OFS(v_ofs), .O_CLK_EN(s_clk_en),
    .O_H_CNT(s_h_cnt), .O_V_CNT(s_v_cnt), .O_HF_CNT(s_hf_cnt), .O_VF_CNT(s_vf_cnt),
    .O_H_BLANKn(s_h_blank_n), .O_V_BLANKn(s_v_blank_n), .O_C_BLANKn(s_c_blank_n),
    .O_H_SYNCn(s_h_sync_n), .O_V_SYNCn(s_v_sync_n),
    .O_LINE_STB(s_line_stb), .O_FRAME_STB(s_frame_stb)
  );

  video_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(24), .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_LEN(3),
    .V_TOTAL(12), .V_ACTIVE(8), .V_SYNC_START(9), .V_SYNC_LEN(2)
  ) dut_o (
    .I_CLK(clk), .RST_n(rst_n), .I_H_FLIP(h_flip), .I_V_FLIP(v_flip),
    .I_H_OFS(h_ofs), .I_V_OFS(v_ofs), .O_CLK_EN(o_clk_en),
    .O_H_CNT(o_h_cnt), .O_V_CNT(o_v_cnt), .O_HF_CNT(o_hf_cnt), .O_VF_CNT(o_vf_cnt),
    .O_H_BLANKn(o_h_blank_n), .O_V_BLANKn(o_v_blank_n), .O_C_BLANKn(o_c_blank_n),
    .O_H_SYNCn(o_h_sync_n), .O_V_SYNCn(o_v_sync_n),
    .O_LINE_STB(o_line_stb), .O_FRAME_STB(o_frame_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One master cycle; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset pulse of three cycles; returns at release (cycle 0).
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Advance to the next enable cycle of the small raster at (h, v).
  task automatic wait_pos(input int h, input int v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (s_clk_en && int'(s_h_cnt) == h && int'(s_v_cnt) == v) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) tmo++;
  endtask

  // Record which pixels of the current small-raster line have HSYNC low.
  task automatic capture_hmask(output logic [31:0] mask);
    mask = '0;
    for (int i = 0; i < 24; i++) begin
      if (!s_h_sync_n) mask[s_h_cnt[4:0]] = 1'b1;
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({d_clk_en, d_h_blank_n, d_v_blank_n, d_c_blank_n, d_h_sync_n, d_v_sync_n,
         d_line_stb, d_frame_stb, d_h_cnt, d_v_cnt, d_hf_cnt, d_vf_cnt}
        !== {8'b01111100, 36'd0}) begin
      n_err++;
      $display("FAIL reset_default: got %h expected %h",
               {d_clk_en, d_h_blank_n, d_v_blank_n, d_c_blank_n, d_h_sync_n, d_v_sync_n,
                d_line_stb, d_frame_stb, d_h_cnt, d_v_cnt, d_hf_cnt, d_vf_cnt},
               {8'b01111100, 36'd0});
    end
    n_vec++;
    if ({s_clk_en, s_h_blank_n, s_v_blank_n, s_c_blank_n, s_h_sync_n, s_v_sync_n,
         s_line_stb, s_frame_stb, s_h_cnt, s_v_cnt, s_hf_cnt, s_vf_cnt}
        !== {8'b01111100, 36'd0}) begin
      n_err++;
      $display("FAIL reset_small: got %h expected %h",
               {s_clk_en, s_h_blank_n, s_v_blank_n, s_c_blank_n, s_h_sync_n, s_v_sync_n,
                s_line_stb, s_frame_stb, s_h_cnt, s_v_cnt, s_hf_cnt, s_vf_cnt},
               {8'b01111100, 36'd0});
    end
    n_vec++;
    if (o_clk_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_div1_en: got %b expected 1", o_clk_en);
    end
    rst_n = 1'b1;
    n_vec++;
    if ({d_clk_en, d_h_cnt} !== {1'b0, 9'd0}) begin
      n_err++;
      $display("FAIL release_cycle0: got en=%b h=%0d expected en=0 h=0", d_clk_en, d_h_cnt);
    end
    tick();
    n_vec++;
    if ({d_clk_en, d_h_cnt} !== {1'b1, 9'd0}) begin
      n_err++;
      $display("FAIL first_enable: got en=%b h=%0d expected en=1 h=0", d_clk_en, d_h_cnt);
    end
    tick();
    n_vec++;
    if ({d_clk_en, d_h_cnt} !== {1'b0, 9'd1}) begin
      n_err++;
      $display("FAIL h_after_enable: got en=%b h=%0d expected en=0 h=1", d_clk_en, d_h_cnt);
    end
  endtask

  // First line of the DK raster: 768 master cycles from release.
  task automatic test_line();
    int stb_n = 0, stb_bad = 0, blank_bad = 0, sync_bad = 0, v_bad = 0;
    int blank_lo = 0, sync_lo = 0;
    do_reset();
    for (int i = 0; i < 768; i++) begin
      if (d_line_stb) begin
        stb_n++;
        if (d_h_cnt !== 9'd383) stb_bad++;
      end
      if (d_h_blank_n !== (d_h_cnt < 9'd256)) blank_bad++;
      if (d_h_sync_n !== !(d_h_cnt >= 9'd288 && d_h_cnt < 9'd320)) sync_bad++;
      if (d_v_cnt !== 9'd0) v_bad++;
      if (!d_h_blank_n) blank_lo++;
      if (!d_h_sync_n) sync_lo++;
      tick();
    end
    n_vec++;
    if (stb_n != 1 || stb_bad != 0) begin
      n_err++;
      $display("FAIL line_stb: got %0d pulses (%0d off H=383) expected 1", stb_n, stb_bad);
    end
    n_vec++;
    if (blank_bad != 0 || blank_lo != 256) begin
      n_err++;
      $display("FAIL line_hblank: got %0d bad, %0d low expected 0 bad, 256 low",
               blank_bad, blank_lo);
    end
    n_vec++;
    if (sync_bad != 0 || sync_lo != 64) begin
      n_err++;
      $display("FAIL line_hsync: got %0d bad, %0d low expected 0 bad, 64 low",
               sync_bad, sync_lo);
    end
    n_vec++;
    if (v_bad != 0 || {d_h_cnt, d_v_cnt} !== {9'd0, 9'd1}) begin
      n_err++;
      $display("FAIL line_wrap: got h=%0d v=%0d (%0d early v) expected h=0 v=1",
               d_h_cnt, d_v_cnt, v_bad);
    end
  endtask

  // Two whole small frames: strobes, vertical blank/sync, combined blank.
  task automatic test_frame();
    int fr_n = 0, fr_bad = 0, ln_n = 0, vb_bad = 0, vs_bad = 0, cb_bad = 0;
    int hs_bad = 0, fl_bad = 0, vs_lo = 0;
    do_reset();
    for (int i = 0; i < 1152; i++) begin
      if (s_frame_stb) begin
        fr_n++;
        if ({s_h_cnt, s_v_cnt} !== {9'd23, 9'd11}) fr_bad++;
      end
      if (s_line_stb) ln_n++;
      if (s_v_blank_n !== (s_v_cnt < 9'd8)) vb_bad++;
      if (s_v_sync_n !== !(s_v_cnt >= 9'd9 && s_v_cnt < 9'd11)) vs_bad++;
      if (s_c_blank_n !== (s_h_cnt < 9'd16 && s_v_cnt < 9'd8)) cb_bad++;
      if (s_h_sync_n !== !(s_h_cnt >= 9'd18 && s_h_cnt < 9'd21)) hs_bad++;
      if (s_hf_cnt !== s_h_cnt || s_vf_cnt !== s_v_cnt) fl_bad++;
      if (!s_v_sync_n) vs_lo++;
      tick();
    end
    n_vec++;
    if (fr_n != 2 || fr_bad != 0) begin
      n_err++;
      $display("FAIL frame_stb: got %0d pulses (%0d misplaced) expected 2", fr_n, fr_bad);
    end
    n_vec++;
    if (ln_n != 24) begin
      n_err++;
      $display("FAIL frame_line_stb: got %0d expected 24", ln_n);
    end
    n_vec++;
    if (vb_bad != 0 || cb_bad != 0) begin
      n_err++;
      $display("FAIL frame_blank: got vbad=%0d cbad=%0d expected 0", vb_bad, cb_bad);
    end
    n_vec++;
    if (vs_bad != 0 || vs_lo != 192) begin
      n_err++;
      $display("FAIL frame_vsync: got %0d bad, %0d low expected 0 bad, 192 low", vs_bad, vs_lo);
    end
    n_vec++;
    if (hs_bad != 0 || fl_bad != 0) begin
      n_err++;
      $display("FAIL frame_hsync_noflip: got hbad=%0d flipbad=%0d expected 0", hs_bad, fl_bad);
    end
  endtask

  task automatic test_h_offset();
    logic [31:0] m;
    do_reset();
    wait_pos(0, 5);
    h_ofs = 4'd3;
    wait_pos(0, 7);
    capture_hmask(m);
    n_vec++;
    if (m !== 32'h001C0000) begin
      n_err++;
      $display("FAIL hofs_same_frame: got %h expected 001c0000", m);
    end
    wait_pos(0, 0);
    capture_hmask(m);
    n_vec++;
    if (m !== 32'h00E00000) begin
      n_err++;
      $display("FAIL hofs_plus3: got %h expected 00e00000", m);
    end
    h_ofs = 4'b1000;
    wait_pos(0, 3);
    capture_hmask(m);
    n_vec++;
    if (m !== 32'h00E00000) begin
      n_err++;
      $display("FAIL hofs_hold_midframe: got %h expected 00e00000", m);
    end
    wait_pos(0, 0);
    capture_hmask(m);
    n_vec++;
    if (m !== 32'h00001C00) begin
      n_err++;
      $display("FAIL hofs_minus8: got %h expected 00001c00", m);
    end
    h_ofs = 4'd5;
    wait_pos(0, 0);
    capture_hmask(m);
    n_vec++;
    if (m !== 32'h00800003) begin
      n_err++;
      $display("FAIL hofs_wrap: got %h expected 00800003", m);
    end
    h_ofs = 4'd0;
  endtask

  // V offset +3 moves the window 9..10 to 0..1, wrapping the frame.
  task automatic test_v_offset();
    logic [3:0] got;
    do_reset();
    wait_pos(0, 3);
    v_ofs = 4'd3;
    wait_pos(0, 9);
    got[0] = s_v_sync_n;
    wait_pos(0, 0);
    got[1] = s_v_sync_n;
    wait_pos(0, 1);
    got[2] = s_v_sync_n;
    wait_pos(0, 2);
    got[3] = s_v_sync_n;
    n_vec++;
    if (got !== 4'b1000) begin
      n_err++;
      $display("FAIL vofs_window: got %b expected 1000", got);
    end
    wait_pos(0, 9);
    n_vec++;
    if (s_v_sync_n !== 1'b1) begin
      n_err++;
      $display("FAIL vofs_old_line: got %b expected 1", s_v_sync_n);
    end
    v_ofs = 4'd0;
  endtask

  task automatic test_flip();
    do_reset();
    wait_pos(0, 2);
    h_flip = 1'b1;
    v_flip = 1'b1;
    wait_pos(0, 3);
    n_vec++;
    if ({s_hf_cnt, s_vf_cnt} !== {9'd0, 9'd3}) begin
      n_err++;
      $display("FAIL flip_before_wrap: got hf=%0d vf=%0d expected 0 3", s_hf_cnt, s_vf_cnt);
    end
    wait_pos(0, 2);
    n_vec++;
    if ({s_hf_cnt, s_vf_cnt} !== {9'd15, 9'd5}) begin
      n_err++;
      $display("FAIL flip_active: got hf=%0d vf=%0d expected 15 5", s_hf_cnt, s_vf_cnt);
    end
    wait_pos(20, 2);
    n_vec++;
    if (s_hf_cnt !== 9'd20) begin
      n_err++;
      $display("FAIL hflip_blank: got %0d expected 20", s_hf_cnt);
    end
    h_flip = 1'b0;
    v_flip = 1'b0;
    wait_pos(0, 6);
    n_vec++;
    if (s_vf_cnt !== 9'd1) begin
      n_err++;
      $display("FAIL vflip_hold_midframe: got %0d expected 1", s_vf_cnt);
    end
    wait_pos(0, 9);
    n_vec++;
    if (s_vf_cnt !== 9'd9) begin
      n_err++;
      $display("FAIL vflip_blank: got %0d expected 9", s_vf_cnt);
    end
    wait_pos(3, 6);
    n_vec++;
    if ({s_hf_cnt, s_vf_cnt} !== {9'd3, 9'd6}) begin
      n_err++;
      $display("FAIL flip_cleared: got hf=%0d vf=%0d expected 3 6", s_hf_cnt, s_vf_cnt);
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    h_flip = 1'b1;
    wait_pos(19, 9);
    n_vec++;
    if ({s_h_blank_n, s_h_sync_n, s_v_blank_n, s_v_sync_n} !== 4'b0000) begin
      n_err++;
      $display("FAIL pre_reset_state: got %b expected 0000",
               {s_h_blank_n, s_h_sync_n, s_v_blank_n, s_v_sync_n});
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_clk_en, s_h_blank_n, s_v_blank_n, s_c_blank_n, s_h_sync_n, s_v_sync_n,
         s_line_stb, s_frame_stb, s_h_cnt, s_v_cnt, s_hf_cnt, s_vf_cnt}
        !== {8'b01111100, 36'd0}) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h",
               {s_clk_en, s_h_blank_n, s_v_blank_n, s_c_blank_n, s_h_sync_n, s_v_sync_n,
                s_line_stb, s_frame_stb, s_h_cnt, s_v_cnt, s_hf_cnt, s_vf_cnt},
               {8'b01111100, 36'd0});
    end
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({s_clk_en, s_h_cnt, s_v_cnt} !== {1'b1, 9'd0, 9'd0}) begin
      n_err++;
      $display("FAIL restart_enable: got en=%b h=%0d v=%0d expected 1 0 0",
               s_clk_en, s_h_cnt, s_v_cnt);
    end
    tick();
    n_vec++;
    if (s_h_cnt !== 9'd1) begin
      n_err++;
      $display("FAIL restart_count: got %0d expected 1", s_h_cnt);
    end
    wait_pos(3, 0);
    n_vec++;
    if (s_hf_cnt !== 9'd3) begin
      n_err++;
      $display("FAIL shadow_cleared: got %0d expected 3", s_hf_cnt);
    end
    h_flip = 1'b0;
  endtask

  task automatic test_clkdiv1();
    int en_n = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (o_clk_en) en_n++;
      tick();
    end
    n_vec++;
    if (en_n != 100) begin
      n_err++;
      $display("FAIL div1_enable: got %0d high expected 100", en_n);
    end
    n_vec++;
    if ({o_h_cnt, o_v_cnt} !== {9'd4, 9'd4}) begin
      n_err++;
      $display("FAIL div1_count: got h=%0d v=%0d expected 4 4", o_h_cnt, o_v_cnt);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    h_flip = 1'b0;
    v_flip = 1'b0;
    h_ofs  = 4'd0;
    v_ofs  = 4'd0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] start");
    test_reset();
    test_line();
    test_frame();
    test_h_offset();
    test_v_offset();
    test_flip();
    test_reset_midline();
    test_clkdiv1();
    n_vec++;
    if (tmo != 0) begin
      n_err++;
      $display("FAIL wait_timeout: got %0d expired waits expected 0", tmo);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
